// File: rtl/ysyx_23060201_ifu.sv
// Instruction fetch unit: one outstanding fetch, holds the returned word for the decoder,
// and applies redirects at any point of the transaction.
module ysyx_23060201_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   pc_d;
    logic              drop_q;
    logic              drop_d;
    logic [XLEN-1:0]   inst_d;
    logic [XLEN-1:0]   inst_pc_d;
    logic [XLEN-1:0]   target;

    // Redirect targets are forced word-aligned so pc never carries low bits.
    assign target        = redirect_pc & ~XLEN'(3);
    assign mem_req_addr  = pc_q;
    assign mem_req_valid = (state_q == REQ) & ~redirect_valid & ~rst;
    assign inst_valid    = (state_q == HOLD) & ~rst;

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        inst_d    = inst;
        inst_pc_d = inst_pc;
        case (state_q)
            REQ: begin
                if (redirect_valid) begin
                    pc_d = target;
                end else if (mem_req_valid && mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = REQ;
                    drop_d  = 1'b0;
                    if (redirect_valid) begin
                        pc_d = target;
                    end else if (!drop_q) begin
                        inst_d    = mem_rsp_data;
                        inst_pc_d = pc_q;
                        state_d   = HOLD;
                    end
                end else if (redirect_valid) begin
                    // The in-flight word belongs to the old path; discard it on arrival.
                    pc_d   = target;
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = target;
                    state_d = REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            inst    <= '0;
            inst_pc <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            inst    <= inst_d;
            inst_pc <= inst_pc_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060201_ifu.sv
// Self-checking bench for ysyx_23060201_ifu: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_ysyx_23060201_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    ysyx_23060201_ifu #(.RESET_PC(32'h8000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: is a fetch in flight, is its word stale, is a word held for the decoder.
    bit          m_init  = 1'b0;
    bit          m_busy  = 1'b0;
    bit          m_stale = 1'b0;
    bit          m_have  = 1'b0;
    logic [31:0] m_pc, m_inst, m_inst_pc;

    // Memory environment: one pending fetch with a countdown before the response.
    bit          pending   = 1'b0;
    int          cnt       = 0;
    logic [31:0] p_addr    = '0;
    int          mem_delay = 0;
    bit          rand_mode = 1'b0;

    function automatic logic [31:0] memfun(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        if (a == 32'h8000_0004) return 32'h0010_0093;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_cycle(input bit r, input bit rv, input logic [31:0] rpc,
                            input bit ir, input bit mr);
        bit rsp;
        bit spur;
        bit exp_req;
        logic [31:0] tgt;
        @(posedge clk);
        #1;
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_ready     = ir;
        mem_req_ready  = mr;
        rsp  = pending && (cnt == 0);
        spur = rand_mode && !pending && ($urandom_range(7) == 0);
        mem_rsp_valid = rsp || spur;
        mem_rsp_data  = rsp ? memfun(p_addr) : $urandom;
        #2;
        // Compare against the model.
        exp_req = !r && !m_busy && !m_have && !rv;
        chk("mem_req_valid", 32'(mem_req_valid), 32'(exp_req));
        chk("inst_valid", 32'(inst_valid), 32'(!r && m_have));
        if (m_init) begin
            chk("mem_req_addr", mem_req_addr, m_pc);
            chk("inst", inst, m_inst);
            chk("inst_pc", inst_pc, m_inst_pc);
        end
        // Memory update.
        if (r) begin
            pending = 1'b0;
        end else begin
            if (rsp) pending = 1'b0;
            else if (pending) cnt--;
            if (mem_req_valid && mem_req_ready) begin
                pending = 1'b1;
                cnt     = rand_mode ? int'($urandom_range(3)) : mem_delay;
                p_addr  = mem_req_addr;
            end
        end
        // Model update.
        tgt = rpc & 32'hFFFF_FFFC;
        if (r) begin
            m_init = 1'b1; m_pc = 32'h8000_0000; m_busy = 1'b0; m_stale = 1'b0;
            m_have = 1'b0; m_inst = '0; m_inst_pc = '0;
        end else if (m_have) begin
            if (rv) begin m_pc = tgt; m_have = 1'b0; end
            else if (ir) begin m_pc = m_pc + 32'd4; m_have = 1'b0; end
        end else if (m_busy) begin
            if (mem_rsp_valid) begin
                m_busy = 1'b0;
                if (rv) m_pc = tgt;
                else if (!m_stale) begin m_have = 1'b1; m_inst = mem_rsp_data; m_inst_pc = m_pc; end
                m_stale = 1'b0;
            end else if (rv) begin
                m_pc = tgt; m_stale = 1'b1;
            end
        end else begin
            if (rv) m_pc = tgt;
            else if (mr) m_busy = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        do_cycle(1, 0, 0, 0, 0);
        do_cycle(1, 0, 0, 0, 0);

        // Zero-wait fetch of the first two words.
        do_cycle(0, 0, 0, 1, 1);
        chk("first_req_valid", 32'(mem_req_valid), 32'd1);
        chk("first_req_addr", mem_req_addr, 32'h8000_0000);
        chk("reset_inst", inst, 32'h0);
        chk("reset_inst_pc", inst_pc, 32'h0);
        chk("reset_inst_valid", 32'(inst_valid), 32'd0);
        do_cycle(0, 0, 0, 1, 1);
        chk("c1_inst_valid", 32'(inst_valid), 32'd0);
        do_cycle(0, 0, 0, 1, 1);
        chk("c2_inst_valid", 32'(inst_valid), 32'd1);
        chk("c2_inst_pc", inst_pc, 32'h8000_0000);
        chk("c2_inst", inst, 32'h0000_0413);
        do_cycle(0, 0, 0, 1, 1);
        do_cycle(0, 0, 0, 1, 1);
        chk("c4_inst_valid", 32'(inst_valid), 32'd0);
        do_cycle(0, 0, 0, 1, 1);
        chk("c5_inst_valid", 32'(inst_valid), 32'd1);
        chk("c5_inst_pc", inst_pc, 32'h8000_0004);
        chk("c5_inst", inst, 32'h0010_0093);
        do_cycle(0, 0, 0, 1, 1);
        chk("c6_req_addr", mem_req_addr, 32'h8000_0008);
        do_cycle(0, 0, 0, 1, 1);

        // Backpressure: four cycles held, then the ready pulse.
        for (int i = 0; i < 4; i++) begin
            do_cycle(0, 0, 0, 0, 1);
            chk("bp_inst_valid", 32'(inst_valid), 32'd1);
            chk("bp_inst_pc", inst_pc, 32'h8000_0008);
            chk("bp_req_valid", 32'(mem_req_valid), 32'd0);
            chk("bp_pc", mem_req_addr, 32'h8000_0008);
        end
        do_cycle(0, 0, 0, 1, 1);
        mem_delay = 2;
        do_cycle(0, 0, 0, 1, 1);
        chk("bp_next_req", 32'(mem_req_valid), 32'd1);
        chk("bp_next_addr", mem_req_addr, 32'h8000_000C);

        // Redirect in WAIT; the late response must be dropped.
        do_cycle(0, 1, 32'h8000_0100, 1, 1);
        chk("rw_inst_valid0", 32'(inst_valid), 32'd0);
        do_cycle(0, 0, 0, 1, 1);
        chk("rw_inst_valid1", 32'(inst_valid), 32'd0);
        do_cycle(0, 0, 0, 1, 1);
        chk("rw_inst_valid2", 32'(inst_valid), 32'd0);
        chk("rw_no_req", 32'(mem_req_valid), 32'd0);
        mem_delay = 0;
        do_cycle(0, 0, 0, 1, 1);
        chk("rw_inst_valid3", 32'(inst_valid), 32'd0);
        chk("rw_req_valid", 32'(mem_req_valid), 32'd1);
        chk("rw_req_addr", mem_req_addr, 32'h8000_0100);
        do_cycle(0, 0, 0, 1, 1);

        // Redirect in HOLD together with inst_ready, misaligned target.
        do_cycle(0, 1, 32'h8000_0203, 1, 1);
        chk("rh_inst_pc", inst_pc, 32'h8000_0100);
        do_cycle(0, 0, 0, 1, 0);
        chk("rh_req_valid", 32'(mem_req_valid), 32'd1);
        chk("rh_req_addr", mem_req_addr, 32'h8000_0200);

        // Wrap of pc at the top of the address space.
        do_cycle(0, 1, 32'hFFFF_FFFC, 1, 0);
        do_cycle(0, 0, 0, 1, 1);
        chk("wrap_req_addr", mem_req_addr, 32'hFFFF_FFFC);
        do_cycle(0, 0, 0, 1, 1);
        do_cycle(0, 0, 0, 1, 1);
        chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        do_cycle(0, 0, 0, 1, 1);
        chk("wrap_next_addr", mem_req_addr, 32'h0000_0000);
        chk("wrap_next_valid", 32'(mem_req_valid), 32'd1);

        // Reset pulse while holding an instruction.
        do_cycle(0, 0, 0, 0, 1);
        do_cycle(0, 0, 0, 0, 1);
        chk("rst_hold_valid", 32'(inst_valid), 32'd1);
        do_cycle(1, 0, 0, 0, 0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        do_cycle(0, 0, 0, 0, 0);
        chk("post_rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("post_rst_req_valid", 32'(mem_req_valid), 32'd1);
        chk("post_rst_addr", mem_req_addr, 32'h8000_0000);

        // Randomized traffic against the model.
        rand_mode = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] rpc;
            rpc = $urandom;
            if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            do_cycle($urandom_range(63) == 0, $urandom_range(7) == 0, rpc,
                     $urandom_range(2) != 0, $urandom_range(3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
